// File: rtl/weight_seq_pkg.sv
// Shared types and defaults for the weight BRAM sequencer.
// Holds the FSM state enum, grant bundle and DEPTH/AW/DW defaults.
package weight_seq_pkg;

  localparam int DEPTH_DEF = 28;
  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } wbseq_state_e;

  typedef struct packed {
    logic ld;
    logic rd;
  } gnt_t;

endpackage

// File: rtl/weight_seq_arbiter.sv
// Grants load or read requests while the sequencer is idle.
// Ports: en (idle), ld_req, rd_req -> gnt; clk/rst_n only with
// WBSEQ_ROUND_ROBIN_EN (alternating grants on contention), else
// load has fixed priority.
module weight_seq_arbiter
  import weight_seq_pkg::*;
(
`ifdef WBSEQ_ROUND_ROBIN_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic en,
  input  logic ld_req,
  input  logic rd_req,
  output gnt_t gnt
);

`ifdef WBSEQ_ROUND_ROBIN_EN
  // Remembers which side won the last contended grant;
  // resets to "read" so the first contention goes to load.
  logic last_rd_q;
  logic last_rd_d;

  always_comb begin
    gnt       = '0;
    last_rd_d = last_rd_q;
    if (en) begin
      if (ld_req && rd_req) begin
        if (last_rd_q) begin
          gnt.ld = 1'b1;
        end else begin
          gnt.rd = 1'b1;
        end
        last_rd_d = ~last_rd_q;
      end else begin
        gnt.ld = ld_req;
        gnt.rd = rd_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rd_q <= 1'b1;
    end else begin
      last_rd_q <= last_rd_d;
    end
  end
`else
  always_comb begin
    gnt    = '0;
    gnt.ld = en & ld_req;
    gnt.rd = en & rd_req & ~ld_req;
  end
`endif

endmodule

// File: rtl/weight_bram_sequencer.sv
// Sequences weight loads into, and burst reads out of, one BRAM port.
// Ports: CLK/RSTN, LD_* write stream, RD_* read stream, ABORT,
// BRAM port ADDR/DI/EN/WE/DO (negedge BRAM), BUSY/DONE status.
// Option: WBSEQ_ROUND_ROBIN_EN selects round-robin arbitration.
module weight_bram_sequencer
  import weight_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          LD_REQ,
  input  logic          LD_VALID,
  input  logic [DW-1:0] LD_DATA,
  output logic          LD_READY,
  input  logic          RD_REQ,
  output logic [DW-1:0] RD_DATA,
  output logic          RD_VALID,
  output logic          RD_LAST,
  input  logic          ABORT,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] DI,
  output logic          EN,
  output logic          WE,
  input  logic [DW-1:0] DO,
  output logic          BUSY,
  output logic          DONE
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  wbseq_state_e  state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;
  logic          done_q, done_d;

  logic en;
  logic we;
  logic ld_ready;
  logic last;
  logic drain_abort;
  gnt_t gnt;

  weight_seq_arbiter u_arb (
`ifdef WBSEQ_ROUND_ROBIN_EN
    .clk    (CLK),
    .rst_n  (RSTN),
`endif
    .en     (state_q == IDLE),
    .ld_req (LD_REQ),
    .rd_req (RD_REQ),
    .gnt    (gnt)
  );

  assign last = (cnt_q == LAST_ADDR);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    en         = 1'b0;
    we         = 1'b0;
    ld_ready   = 1'b0;
    rd_data_d  = '0;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gnt.ld) begin
          state_d = LOAD;
        end else if (gnt.rd) begin
          state_d = READ;
        end
      end
      LOAD: begin
        if (ABORT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          ld_ready = 1'b1;
          if (LD_VALID) begin
            en = 1'b1;
            we = 1'b1;
            if (last) begin
              state_d = IDLE;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + AW'(1);
            end
          end
        end
      end
      READ: begin
        if (ABORT) begin
          // Address in this cycle is not issued and its
          // word never gets a valid beat.
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          en         = 1'b1;
          rd_valid_d = 1'b1;
          // BRAM has updated DO on the negedge of this cycle.
          rd_data_d  = DO;
          if (last) begin
            state_d   = DRAIN;
            cnt_d     = '0;
            rd_last_d = 1'b1;
            done_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
    end
  end

  // The final word sits in registers during DRAIN, so an abort
  // there has to suppress it combinationally.
  assign drain_abort = (state_q == DRAIN) & ABORT;

  assign ADDR     = en ? cnt_q : '0;
  assign DI       = we ? LD_DATA : '0;
  assign EN       = en;
  assign WE       = we;
  assign LD_READY = ld_ready;
  assign RD_DATA  = rd_data_q;
  assign RD_VALID = rd_valid_q & ~drain_abort;
  assign RD_LAST  = rd_last_q & ~drain_abort;
  assign DONE     = done_q & ~drain_abort;
  assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_weight_bram_sequencer.sv
// Directed bench for weight_bram_sequencer with a negedge BRAM model.
// Expected arbitration order depends on WBSEQ_ROUND_ROBIN_EN.
module tb_weight_bram_sequencer;

  logic        CLK;
  logic        RSTN;
  logic        LD_REQ;
  logic        LD_VALID;
  logic [15:0] LD_DATA;
  logic        LD_READY;
  logic        RD_REQ;
  logic [15:0] RD_DATA;
  logic        RD_VALID;
  logic        RD_LAST;
  logic        ABORT;
  logic [4:0]  ADDR;
  logic [15:0] DI;
  logic        EN;
  logic        WE;
  logic [15:0] DO;
  logic        BUSY;
  logic        DONE;

  int vectors;
  int miscompares;
  int vcnt;

  logic [15:0] mem [0:27];

  weight_bram_sequencer dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .LD_REQ   (LD_REQ),
    .LD_VALID (LD_VALID),
    .LD_DATA  (LD_DATA),
    .LD_READY (LD_READY),
    .RD_REQ   (RD_REQ),
    .RD_DATA  (RD_DATA),
    .RD_VALID (RD_VALID),
    .RD_LAST  (RD_LAST),
    .ABORT    (ABORT),
    .ADDR     (ADDR),
    .DI       (DI),
    .EN       (EN),
    .WE       (WE),
    .DO       (DO),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (EN && ADDR < 5'd28) begin
      if (WE) mem[ADDR] <= DI;
      else    DO <= mem[ADDR];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(ADDR), 0);
    chk({tag, "_di"}, 32'(DI), 0);
    chk({tag, "_ctl"},
        {24'd0, EN, WE, LD_READY, RD_VALID,
         RD_LAST, BUSY, DONE, 1'b0}, 0);
    chk({tag, "_rdata"}, 32'(RD_DATA), 0);
  endtask

  initial begin
    logic exp_ld;
    vectors     = 0;
    miscompares = 0;
    RSTN     = 1'b0;
    LD_REQ   = 1'b0;
    LD_VALID = 1'b0;
    LD_DATA  = 16'h0;
    RD_REQ   = 1'b0;
    ABORT    = 1'b0;
    DO       = 16'h0;
    tick();
    tick();
    #1;
    chk_all_zero("reset");
    RSTN = 1'b1;

    // Continuous load of 0x0001..0x001C; early RD_REQ is ignored.
    tick();
    LD_REQ = 1'b1;
    tick();
    LD_REQ = 1'b0;
    for (int i = 0; i < 28; i++) begin
      LD_VALID = 1'b1;
      LD_DATA  = 16'(i + 1);
      RD_REQ   = (i < 5);
      #1;
      chk("ld_addr", 32'(ADDR), i);
      chk("ld_di", 32'(DI), i + 1);
      chk("ld_ctl", {29'd0, EN, WE, LD_READY}, 7);
      chk("ld_done", 32'(DONE), 0);
      tick();
    end
    LD_VALID = 1'b0;
    RD_REQ   = 1'b0;
    #1;
    chk("ld_done_pulse", 32'(DONE), 1);
    chk("ld_busy_after", 32'(BUSY), 0);
    tick();
    #1;
    chk("ld_done_clear", 32'(DONE), 0);
    chk("rdreq_not_latched", 32'(BUSY), 0);

    // Full read burst.
    RD_REQ = 1'b1;
    tick();
    RD_REQ = 1'b0;
    for (int c = 0; c < 28; c++) begin
      #1;
      chk("rd_addr", 32'(ADDR), c);
      chk("rd_en_we", {30'd0, EN, WE}, 2);
      if (c > 0) begin
        chk("rd_valid", 32'(RD_VALID), 1);
        chk("rd_data", 32'(RD_DATA), c);
        chk("rd_last_early", {30'd0, RD_LAST, DONE}, 0);
      end else begin
        chk("rd_valid_first", 32'(RD_VALID), 0);
      end
      tick();
    end
    #1;
    chk("drain_data", 32'(RD_DATA), 16'h001C);
    chk("drain_flags",
        {28'd0, RD_VALID, RD_LAST, DONE, BUSY}, 15);
    chk("drain_en", 32'(EN), 0);
    tick();
    #1;
    chk("post_drain", {29'd0, BUSY, RD_VALID, DONE}, 0);

    // Gapped load: 28 writes over 55 cycles.
    LD_REQ = 1'b1;
    tick();
    LD_REQ = 1'b0;
    for (int c = 0; c < 55; c++) begin
      LD_VALID = (c % 2 == 0);
      LD_DATA  = LD_VALID ? 16'(16'h0100 + c / 2) : 16'hDEAD;
      #1;
      if (c % 2 == 0) begin
        chk("gap_addr", 32'(ADDR), c / 2);
        chk("gap_di", 32'(DI), 16'h0100 + c / 2);
        chk("gap_we", {30'd0, EN, WE}, 3);
      end else begin
        chk("gap_idle_en", {30'd0, EN, WE}, 0);
      end
      chk("gap_done", 32'(DONE), 0);
      tick();
    end
    LD_VALID = 1'b0;
    #1;
    chk("gap_done_pulse", {30'd0, DONE, BUSY}, 2);
    tick();

    // Contention twice; each grant is aborted after inspection.
`ifdef WBSEQ_ROUND_ROBIN_EN
    exp_ld = 1'b0;
`else
    exp_ld = 1'b1;
`endif
    LD_REQ = 1'b1;
    RD_REQ = 1'b1;
    tick();
    LD_REQ = 1'b0;
    RD_REQ = 1'b0;
    #1;
    chk("arb1_load", {30'd0, LD_READY, EN}, 2);
    ABORT = 1'b1;
    #1;
    chk("abort_ld_ready", 32'(LD_READY), 0);
    tick();
    ABORT = 1'b0;
    #1;
    chk("abort_ld_idle", {30'd0, BUSY, DONE}, 0);
    LD_REQ = 1'b1;
    RD_REQ = 1'b1;
    tick();
    LD_REQ = 1'b0;
    RD_REQ = 1'b0;
    #1;
    chk("arb2_grant", {30'd0, LD_READY, EN},
        {30'd0, exp_ld, ~exp_ld});
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    #1;
    chk("arb2_idle", 32'(BUSY), 0);

    // Abort a read burst at address 10.
    vcnt = 0;
    RD_REQ = 1'b1;
    tick();
    RD_REQ = 1'b0;
    for (int c = 0; c < 11; c++) begin
      #1;
      if (RD_VALID) vcnt++;
      if (c == 10) begin
        chk("abort_rd_addr", 32'(ADDR), 10);
        chk("abort_rd_word9", 32'(RD_DATA), 16'h0109);
        ABORT = 1'b1;
        #1;
        chk("abort_rd_en", 32'(EN), 0);
      end
      tick();
    end
    ABORT = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (RD_VALID) vcnt++;
      chk("abort_rd_quiet",
          {29'd0, BUSY, RD_LAST, DONE}, 0);
      tick();
    end
    chk("abort_rd_vcount", 32'(vcnt), 10);

    // Reset asserted mid-load at address 15.
    LD_REQ = 1'b1;
    tick();
    LD_REQ = 1'b0;
    for (int i = 0; i < 16; i++) begin
      LD_VALID = 1'b1;
      LD_DATA  = 16'(16'h0200 + i);
      #1;
      if (i == 15) begin
        chk("rst_at_addr", 32'(ADDR), 15);
        RSTN = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        RSTN = 1'b1;
      end
      tick();
    end
    LD_VALID = 1'b0;
    #1;
    chk("rst_idle", 32'(BUSY), 0);
    LD_REQ = 1'b1;
    tick();
    LD_REQ   = 1'b0;
    LD_VALID = 1'b1;
    LD_DATA  = 16'h0300;
    #1;
    chk("restart_addr", 32'(ADDR), 0);
    chk("restart_we", {30'd0, EN, WE}, 3);
    ABORT = 1'b1;
    tick();
    ABORT    = 1'b0;
    LD_VALID = 1'b0;
    #1;
    chk("final_idle", 32'(BUSY), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
